// File: rtl/pipeline_run_sequencer_if.sv
// Front-panel bus between board I/O and the pipeline run sequencer.
// The slave side is the sequencer; the master side is the board/bench.
interface pipeline_run_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       switches;
  logic [2:0]       buttons;
  logic             pipe_en;
  logic             pipe_flush;
  logic             pipe_clr;
  logic [1:0]       ctrl_mode;
  logic             busy;
  logic [CNT_W-1:0] step_count;
  logic             err;

  modport master (
    output switches, buttons,
    input  pipe_en, pipe_flush, pipe_clr, ctrl_mode, busy, step_count, err
  );

  modport slave (
    input  switches, buttons,
    output pipe_en, pipe_flush, pipe_clr, ctrl_mode, busy, step_count, err
  );
endinterface

// File: rtl/pipeline_run_sequencer.sv
// Front-panel sequencer: synchronises/debounces go/halt/clear buttons and drives
// the pipeline stage enables through RUN, STEP, BURST and DRAIN operations.
module pipeline_run_sequencer #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned BURST_LEN    = 3,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pipeline_run_sequencer_if.slave bus
);

  localparam int unsigned DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int unsigned LEN_MAX = (BURST_LEN > DRAIN_CYCLES) ? BURST_LEN : DRAIN_CYCLES;
  localparam int unsigned LEN_W   = $clog2(LEN_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    BURST,
    DRAIN,
    CLEAR
  } state_t;

  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      level;
  logic [2:0]      level_d;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  logic go;
  logic halt;
  logic clr;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_next;
  logic [1:0]       mode_q;
  logic [1:0]       mode_next;
  logic [1:0]       sw_mode;
  logic             sw_onehot;
  logic             err_set;
  logic             err_q;
  logic [CNT_W-1:0] step_q;
  logic             en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.buttons;
      sync2 <= sync1;
    end
  end

  // Level only moves after DB_CYCLES consecutive cycles disagreeing with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= '0;
      level_d <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      level_d <= level;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = level & ~level_d;
  assign go    = press[0];
  assign halt  = press[1];
  assign clr   = press[2];

  always_comb begin
    sw_onehot = $onehot(bus.switches);
    sw_mode   = 2'd3;
    if (bus.switches[3]) begin
      sw_mode = 2'd0;
    end else if (bus.switches[2]) begin
      sw_mode = 2'd1;
    end else if (bus.switches[1]) begin
      sw_mode = 2'd2;
    end
  end

  // Priority clear > halt > go: a clear event overrides whatever the state wants.
  always_comb begin
    state_next = state;
    len_next   = len_cnt;
    mode_next  = mode_q;
    err_set    = 1'b0;
    if (clr) begin
      state_next = CLEAR;
      len_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (go && !halt) begin
            if (sw_onehot) begin
              mode_next = sw_mode;
              case (sw_mode)
                2'd0: state_next = RUN;
                2'd1: state_next = STEP;
                2'd2: begin
                  state_next = BURST;
                  len_next   = LEN_W'(BURST_LEN);
                end
                default: begin
                  state_next = DRAIN;
                  len_next   = LEN_W'(DRAIN_CYCLES);
                end
              endcase
            end else begin
              err_set = 1'b1;
            end
          end
        end
        RUN: begin
          if (halt) begin
            state_next = IDLE;
          end
        end
        STEP: state_next = IDLE;
        BURST, DRAIN: begin
          if (halt || len_cnt == LEN_W'(1)) begin
            state_next = IDLE;
            len_next   = '0;
          end else begin
            len_next = len_cnt - LEN_W'(1);
          end
        end
        CLEAR: state_next = IDLE;
        default: begin
          state_next = IDLE;
          len_next   = '0;
        end
      endcase
    end
  end

  assign en = (state == RUN) || (state == STEP) || (state == BURST) || (state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      len_cnt <= '0;
      mode_q  <= '0;
    end else begin
      state   <= state_next;
      len_cnt <= len_next;
      mode_q  <= mode_next;
    end
  end

  // Entering CLEAR wins over a same-cycle increment so the count reads 0 while pipe_clr is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q  <= 1'b0;
      step_q <= '0;
    end else begin
      if (state_next == CLEAR) begin
        err_q  <= 1'b0;
        step_q <= '0;
      end else begin
        if (err_set) begin
          err_q <= 1'b1;
        end
        if (en && step_q != '1) begin
          step_q <= step_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.pipe_en    = en;
  assign bus.pipe_flush = (state == DRAIN);
  assign bus.pipe_clr   = (state == CLEAR);
  assign bus.busy       = (state != IDLE);
  assign bus.ctrl_mode  = mode_q;
  assign bus.step_count = step_q;
  assign bus.err        = err_q;

endmodule
